// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared definitions for the gate vector checker:
//   - FSM state encodings and the state enum used by the checker top.
//   - Truth-table constants for common 2-input gates. Bit i of a table is
//     the expected gate output when the applied vector equals i
//     (vector MSB drives input a, LSB drives input b).
package gate_check_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_t;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_vector_checker_settle_timer.sv
// settle_timer
// 4-bit loadable down-counter that times how long each vector is held on
// the gate before its output is sampled.
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset (count returns to 0)
//   i_load     load i_loadVal this cycle (takes priority over i_en)
//   i_loadVal  value to load
//   i_en       decrement by one while the count is non-zero
//   o_zero     count is currently zero
module settle_timer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [3:0] i_loadVal,
    input  logic       i_en,
    output logic       o_zero
);

    logic [3:0] r_count;

    // The count stops at zero rather than wrapping, so a stray enable
    // after expiry cannot restart a long hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_en && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker
// Exhaustive stimulus/response checker for a small combinational gate.
// Walks every input vector, holds each for SETTLE cycles, samples the gate
// output for one cycle and compares it with the EXPECT truth table.
// Parameters:
//   N_IN    number of gate inputs
//   EXPECT  expected truth table, bit i = expected output for vector i
//   SETTLE  hold cycles per vector before sampling (1..15)
// Ports:
//   i_clk         rising-edge clock
//   i_rst         asynchronous active-high reset
//   i_start       request a full run (only honoured when idle)
//   o_vec         vector applied to the gate (MSB drives a, LSB drives b)
//   i_y_in        gate output under test
//   o_busy        run in progress, through the end-of-run pulse
//   o_done        one-cycle end-of-run pulse
//   o_pass        last run had no mismatches (held until the next start)
//   o_err_count   mismatching vectors in the last or current run
//   o_fail_valid  a mismatch has been captured this run
//   o_fail_vec    first mismatching vector
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = TT_AND2,
    parameter int                      SETTLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic [N_IN-1:0] o_vec,
    input  logic            i_y_in,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_count,
    output logic            o_fail_valid,
    output logic [N_IN-1:0] o_fail_vec
);

    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

    state_t            r_state;
    logic [N_IN-1:0]   r_vec;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN:0]     r_errCount;
    logic              r_failValid;
    logic [N_IN-1:0]   r_failVec;

    logic              w_expectBit;
    logic              w_lastVec;
    logic              w_timerLoad;
    logic              w_timerEn;
    logic              w_timerZero;

    assign w_expectBit = EXPECT[r_vec];
    assign w_lastVec   = (r_vec == LAST_VEC);

    // The timer is reloaded both when a run is accepted and when the
    // checker steps to the next vector, so every vector gets the same hold.
    assign w_timerLoad = ((r_state == S_IDLE) && i_start) ||
                         ((r_state == S_SAMPLE) && !w_lastVec);
    assign w_timerEn   = (r_state == S_SETTLE);

    settle_timer u_settleTimer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_timerLoad),
        .i_loadVal (SETTLE_LOAD),
        .i_en      (w_timerEn),
        .o_zero    (w_timerZero)
    );

    // Run controller. The DONE state registers done/pass, so the pulse is
    // visible in the cycle after DONE while the FSM is already back in IDLE;
    // busy is held through that same cycle. The compare is written as an
    // equality with the mismatch in the else branch so an unknown gate
    // output is counted as a failure.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_errCount  <= '0;
            r_failValid <= 1'b0;
            r_failVec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state     <= S_SETTLE;
                        r_vec       <= '0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_errCount  <= '0;
                        r_failValid <= 1'b0;
                        r_failVec   <= '0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (w_timerZero) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (i_y_in == w_expectBit) begin
                        r_errCount <= r_errCount;
                    end else begin
                        r_errCount <= r_errCount + (N_IN+1)'(1);
                        if (!r_failValid) begin
                            r_failValid <= 1'b1;
                            r_failVec   <= r_vec;
                        end
                    end
                    if (w_lastVec) begin
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + N_IN'(1);
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b1;
                    r_pass  <= (r_errCount == '0);
                    r_vec   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_vec        = r_vec;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_errCount;
    assign o_fail_valid = r_failValid;
    assign o_fail_vec   = r_failVec;

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Self-checking stimulus/response stage for small combinational gates (and_gate, or_gate, ...).
- Drives every input combination onto the gate under test, waits a settle interval, samples the gate output and compares it against a parameterised truth table.
- Counts mismatches and reports pass/fail.
- Sits directly around the gate: its vec output feeds the gate inputs; the gate's y feeds back into y_in.

Parameters:
- N_IN, 2: number of gate inputs; vectors run 0 .. 2^N_IN-1.
- EXPECT, 4'b1000: expected truth table, width 2^N_IN; bit i = expected y for vec==i. The default is AND.
- SETTLE, 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a full check run; sampled only in IDLE.
- vec  out  N_IN  gate input vector; vec[N_IN-1] drives a (MSB), vec[0] drives b.
- y_in  in  1  gate output under test.
- busy  out  1  high from the first cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when err_count==0 at end of run; held until the next accepted start.
- err_count  out  N_IN+1  number of mismatching vectors in the last or current run.
- fail_valid  out  1  a mismatch has been captured this run.
- fail_vec  out  N_IN  first mismatching vector; meaningful only when fail_valid==1.

Behaviour:
- Reset (async, immediate): state=IDLE; vec, busy, done, pass, err_count, fail_valid and fail_vec all 0.
- All outputs are registered.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE -> SETTLE when start==1.
  - On that edge: vec=0, settle counter=SETTLE-1, err_count=0, fail_valid=0, fail_vec=0, pass=0.
- SETTLE:
  - Holds vec and decrements the counter each cycle.
  - Moves to SAMPLE when the counter reaches 0, so it lasts exactly SETTLE cycles.
- SAMPLE (1 cycle): compares y_in with EXPECT[vec].
  - On mismatch: err_count+1; if fail_valid==0, capture fail_vec=vec and set fail_valid=1.
  - If vec==2^N_IN-1: go to DONE.
  - Otherwise: vec+1, reload the counter, go to SETTLE.
- DONE (1 cycle): done=1, busy=1, pass=(err_count==0) using the final count including the last sample; vec returns to 0; then IDLE.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done is high 2^N_IN*(SETTLE+1)+1 clocks after the edge that accepted start.
  - N_IN=2, SETTLE=1 gives 9 clocks.
- Boundary cases:
  - start while busy or in DONE: ignored, no restart.
  - start held high continuously: a new run begins on the first IDLE cycle after DONE.
  - err_count cannot overflow (maximum 2^N_IN fits in N_IN+1 bits); no saturation logic.
  - vec never wraps within a run; the last vector goes to DONE.
  - rst mid-run: abort immediately to reset values; no done pulse; the prior pass/err_count are lost.
  - y_in X/Z: counts as mismatch.

Decomposition:
- Shared package gate_check_pkg:
  - FSM state encodings (2-bit localparams).
  - Truth-table constants TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_NAND2=4'b0111.
- One sub-module, settle_timer: loadable down-counter with load value, enable and zero flag, 4 bits wide.

Test Plan:
- Real and_gate, defaults, one start pulse -> vec 0,1,2,3 each held 2 cycles; done at clock 9; pass=1, err_count=0, fail_valid=0.
- y_in tied 0, EXPECT=TT_AND2 -> done at clock 9; err_count=1, fail_valid=1, fail_vec=2'b11, pass=0.
- NAND connected, EXPECT=TT_AND2 -> err_count=4, fail_vec=2'b00, pass=0.
- start held high throughout -> exactly one done per 10-clock period (9 run + 1 IDLE); err_count cleared at each new start.
- rst pulsed while vec==2 -> all outputs 0 immediately, no done; a following start gives a full passing run, done 9 clocks later.
- SETTLE=3, EXPECT=TT_XOR2, xor gate connected -> each vector held 4 cycles; done at clock 17; pass=1.
